// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: rotates one active-low anode per DWELL cycles and feeds that digit's code to a shared decoder.
// A loaded frame is double-buffered and committed only at a frame wrap; load_ready drops while a frame is pending.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL        = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_digits,
    input  logic [NUM_DIGITS-1:0]   load_blank,
    input  logic                    blink_en,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW_W  = $clog2(DWELL);
    localparam int BL_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BL_W-1:0]  BLINK_LAST = BL_W'(BLINK_FRAMES - 1);

    logic [DW_W-1:0]         dwell_q, dwell_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] live_digits_q, live_digits_d;
    logic [NUM_DIGITS-1:0]   live_blank_q, live_blank_d;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    pend_q, pend_d;
    logic [BL_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic                    frame_start_q, frame_start_d;

    logic                    dwell_end;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   an_onehot;

    always_comb begin
        dwell_d       = dwell_q;
        idx_d         = idx_q;
        live_digits_d = live_digits_q;
        live_blank_d  = live_blank_q;
        pend_digits_d = pend_digits_q;
        pend_blank_d  = pend_blank_q;
        pend_d        = pend_q;
        blink_cnt_d   = blink_cnt_q;
        phase_d       = phase_q;

        dwell_end     = (dwell_q == DWELL_LAST);
        wrap          = dwell_end && (idx_q == IDX_LAST);
        frame_start_d = wrap;

        if (dwell_end) begin
            dwell_d = '0;
            idx_d   = wrap ? '0 : idx_q + 1'b1;
        end else begin
            dwell_d = dwell_q + 1'b1;
        end

        // Commit and accept are mutually exclusive because both key off pend_q.
        if (wrap && pend_q) begin
            live_digits_d = pend_digits_q;
            live_blank_d  = pend_blank_q;
            pend_d        = 1'b0;
        end
        if (load_valid && !pend_q) begin
            pend_digits_d = load_digits;
            pend_blank_d  = load_blank;
            pend_d        = 1'b1;
        end

        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (wrap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q       <= '0;
            idx_q         <= '0;
            live_digits_q <= '1;
            live_blank_q  <= '1;
            pend_digits_q <= '0;
            pend_blank_q  <= '0;
            pend_q        <= 1'b0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
            frame_start_q <= 1'b1;
        end else begin
            dwell_q       <= dwell_d;
            idx_q         <= idx_d;
            live_digits_q <= live_digits_d;
            live_blank_q  <= live_blank_d;
            pend_digits_q <= pend_digits_d;
            pend_blank_q  <= pend_blank_d;
            pend_q        <= pend_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            frame_start_q <= frame_start_d;
        end
    end

    // phase_q is forced low whenever blink_en is low, so it alone gates the dark phase.
    always_comb begin
        an_onehot        = '0;
        an_onehot[idx_q] = 1'b1;
        an               = ~an_onehot;
        if (live_blank_q[idx_q] || phase_q) begin
            hex_out = 4'hF;
        end else begin
            hex_out = live_digits_q[idx_q*4 +: 4];
        end
    end

    assign load_ready  = ~pend_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL=3, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_digits;
    logic [3:0]  load_blank;
    logic        blink_en;
    logic [3:0]  hex_out;
    logic [3:0]  an;
    logic        frame_start;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DWELL        (3),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_digits (load_digits),
        .load_blank  (load_blank),
        .blink_en    (blink_en),
        .hex_out     (hex_out),
        .an          (an),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        logic [3:0] an_tbl [12];
        logic [3:0] exp_an;
        logic       exp_fs;
        an_tbl = '{4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101,
                   4'b1011, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b0111};
        do_reset();
        chk_cnt++;
        if (load_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", load_ready);
        else pass_cnt++;
        for (int c = 0; c < 24; c++) begin
            run_to(c);
            exp_an = an_tbl[c % 12];
            exp_fs = (c == 0 || c == 12);
            chk_cnt++;
            if (an !== exp_an) $display("FAIL reset_an cyc=%0d got %b want %b", c, an, exp_an);
            else pass_cnt++;
            chk_cnt++;
            if (hex_out !== 4'hF) $display("FAIL reset_hex cyc=%0d got %h want f", c, hex_out);
            else pass_cnt++;
            chk_cnt++;
            if (frame_start !== exp_fs) $display("FAIL reset_fs cyc=%0d got %b want %b", c, frame_start, exp_fs);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_commit();
        logic [3:0] dig_tbl [4];
        dig_tbl = '{4'h1, 4'h2, 4'h3, 4'h4};
        do_reset();
        run_to(4);
        load_digits = 16'h4321;
        load_blank  = 4'b0000;
        load_valid  = 1'b1;
        run_to(5);
        load_valid = 1'b0;
        for (int c = 5; c <= 11; c++) begin
            run_to(c);
            chk_cnt++;
            if (load_ready !== 1'b0) $display("FAIL commit_ready_low cyc=%0d got %b want 0", c, load_ready);
            else pass_cnt++;
            chk_cnt++;
            if (hex_out !== 4'hF) $display("FAIL commit_early cyc=%0d got %h want f", c, hex_out);
            else pass_cnt++;
        end
        run_to(12);
        chk_cnt++;
        if (load_ready !== 1'b1) $display("FAIL commit_ready_back got %b want 1", load_ready);
        else pass_cnt++;
        for (int c = 12; c < 24; c++) begin
            run_to(c);
            chk_cnt++;
            if (hex_out !== dig_tbl[(c - 12) / 3])
                $display("FAIL commit_hex cyc=%0d got %h want %h", c, hex_out, dig_tbl[(c - 12) / 3]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_to(1);
        load_digits = 16'h1111;
        load_blank  = 4'b0000;
        load_valid  = 1'b1;
        run_to(2);
        load_digits = 16'hABCD;
        for (int c = 2; c <= 11; c++) begin
            run_to(c);
            chk_cnt++;
            if (load_ready !== 1'b0) $display("FAIL bp_ready cyc=%0d got %b want 0", c, load_ready);
            else pass_cnt++;
        end
        run_to(12);
        chk_cnt++;
        if (hex_out !== 4'h1) $display("FAIL bp_first_frame got %h want 1", hex_out);
        else pass_cnt++;
        chk_cnt++;
        if (load_ready !== 1'b1) $display("FAIL bp_ready_back got %b want 1", load_ready);
        else pass_cnt++;
        run_to(13);
        load_valid = 1'b0;
        chk_cnt++;
        if (load_ready !== 1'b0) $display("FAIL bp_accept got %b want 0", load_ready);
        else pass_cnt++;
        run_to(24);
        chk_cnt++;
        if (hex_out !== 4'hD) $display("FAIL bp_second_d0 got %h want d", hex_out);
        else pass_cnt++;
        run_to(27);
        chk_cnt++;
        if (hex_out !== 4'hC) $display("FAIL bp_second_d1 got %h want c", hex_out);
        else pass_cnt++;
    endtask

    task automatic test_wrap_load();
        do_reset();
        run_to(11);
        load_digits = 16'h9876;
        load_blank  = 4'b0000;
        load_valid  = 1'b1;
        run_to(12);
        load_valid = 1'b0;
        chk_cnt++;
        if (hex_out !== 4'hF) $display("FAIL wrap_not_committed got %h want f", hex_out);
        else pass_cnt++;
        chk_cnt++;
        if (load_ready !== 1'b0) $display("FAIL wrap_pending got %b want 0", load_ready);
        else pass_cnt++;
        run_to(23);
        chk_cnt++;
        if (hex_out !== 4'hF) $display("FAIL wrap_still_old got %h want f", hex_out);
        else pass_cnt++;
        run_to(24);
        chk_cnt++;
        if (hex_out !== 4'h6) $display("FAIL wrap_commit_d0 got %h want 6", hex_out);
        else pass_cnt++;
        run_to(27);
        chk_cnt++;
        if (hex_out !== 4'h7) $display("FAIL wrap_commit_d1 got %h want 7", hex_out);
        else pass_cnt++;
    endtask

    task automatic test_blanking();
        int         cyc_tbl [4];
        logic [3:0] an_tbl  [4];
        logic [3:0] hex_tbl [4];
        cyc_tbl = '{12, 15, 18, 21};
        an_tbl  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        hex_tbl = '{4'hF, 4'h7, 4'hF, 4'h5};
        do_reset();
        load_digits = 16'h5678;
        load_blank  = 4'b0101;
        load_valid  = 1'b1;
        run_to(1);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_to(cyc_tbl[i]);
            chk_cnt++;
            if (hex_out !== hex_tbl[i]) $display("FAIL blank_hex digit=%0d got %h want %h", i, hex_out, hex_tbl[i]);
            else pass_cnt++;
            chk_cnt++;
            if (an !== an_tbl[i]) $display("FAIL blank_an digit=%0d got %b want %b", i, an, an_tbl[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_blink();
        int         cyc_tbl [9];
        logic [3:0] hex_tbl [9];
        cyc_tbl = '{12, 35, 36, 47, 59, 60, 83, 84, 89};
        hex_tbl = '{4'h1, 4'h4, 4'hF, 4'hF, 4'hF, 4'h1, 4'h4, 4'hF, 4'hF};
        do_reset();
        load_digits = 16'h4321;
        load_blank  = 4'b0000;
        load_valid  = 1'b1;
        run_to(1);
        load_valid = 1'b0;
        run_to(12);
        blink_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_to(cyc_tbl[i]);
            chk_cnt++;
            if (hex_out !== hex_tbl[i]) $display("FAIL blink_hex cyc=%0d got %h want %h", cyc_tbl[i], hex_out, hex_tbl[i]);
            else pass_cnt++;
        end
        run_to(90);
        blink_en = 1'b0;
        run_to(91);
        chk_cnt++;
        if (hex_out !== 4'h3) $display("FAIL blink_off got %h want 3", hex_out);
        else pass_cnt++;
        chk_cnt++;
        if (an !== 4'b1011) $display("FAIL blink_off_an got %b want 1011", an);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        run_to(1);
        load_digits = 16'h2222;
        load_blank  = 4'b0000;
        load_valid  = 1'b1;
        run_to(2);
        load_valid = 1'b0;
        chk_cnt++;
        if (load_ready !== 1'b0) $display("FAIL midrst_pending got %b want 0", load_ready);
        else pass_cnt++;
        run_to(7);
        rst         = 1'b1;
        load_digits = 16'h3333;
        load_valid  = 1'b1;
        tick();
        rst        = 1'b0;
        load_valid = 1'b0;
        cyc        = 0;
        chk_cnt++;
        if (an !== 4'b1110) $display("FAIL midrst_an got %b want 1110", an);
        else pass_cnt++;
        chk_cnt++;
        if (hex_out !== 4'hF) $display("FAIL midrst_hex got %h want f", hex_out);
        else pass_cnt++;
        chk_cnt++;
        if (load_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", load_ready);
        else pass_cnt++;
        chk_cnt++;
        if (frame_start !== 1'b1) $display("FAIL midrst_fs got %b want 1", frame_start);
        else pass_cnt++;
        run_to(12);
        chk_cnt++;
        if (hex_out !== 4'hF) $display("FAIL midrst_discard1 got %h want f", hex_out);
        else pass_cnt++;
        run_to(24);
        chk_cnt++;
        if (hex_out !== 4'hF) $display("FAIL midrst_discard2 got %h want f", hex_out);
        else pass_cnt++;
    endtask

    initial begin
        rst         = 1'b1;
        load_valid  = 1'b0;
        load_digits = 16'h0000;
        load_blank  = 4'b0000;
        blink_en    = 1'b0;
        test_reset();
        test_load_commit();
        test_backpressure();
        test_wrap_load();
        test_blanking();
        test_blink();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
